if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//   Instruction-fetch stage: owns the PC, issues word fetches to the instruction-memory port,
//   predecodes JAL/BRANCH for next-PC selection and presents pc/instruction/prediction to the
//   IF/ID pipeline register. Redirected by EX on mispredict (discard + target).
// PARAMETERS
//   RESET_PC      32'h0  PC loaded on reset
//   ICACHE_LINES  64     direct-mapped I-cache lines, 1 word each, power of 2 (ICACHE_EN only)
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous, active-low reset
//   stall_state     in   6   stall bus; bit2=1 means IF/ID holds (does not load)
//   discard         in   1   EX mispredict: flush and redirect
//   discard_target  in   32  redirect PC; bits[1:0] forced to 0
//   pred_taken      in   1   predictor answer for pred_index
//   pred_index      out  32  PC of the word now being fetched (predictor lookup)
//   mem_req         out  1   fetch request
//   mem_addr        out  32  fetch word address, bits[1:0]=0
//   mem_ready       in   1   1-cycle pulse: mem_rdata valid, request complete
//   mem_rdata       in   32  fetched word
//   if_pc           out  32  PC to IF/ID
//   if_instruction  out  32  instruction to IF/ID; 32'h0 = bubble
//   if_prediction   out  1   taken prediction to IF/ID
// BEHAVIOUR
//   - Registers: pc (next to deliver), req_addr, buf_pc/buf_instr/buf_pred, state.
//   - States: FETCH, DROP, HOLD. Reset: state=FETCH, pc=req_addr=RESET_PC, buffers=0.
//   - Memory handshake: mem_req=1 in FETCH and DROP; mem_addr=req_addr held stable until
//     mem_ready. mem_req may stay high back-to-back; a new address is valid the cycle after ready.
//   - Predecode (opcode=instr[6:0]): JAL 1101111 -> taken=1, next=pc+J-imm;
//     BRANCH 1100011 -> taken=pred_taken, next=taken ? pc+B-imm : pc+4; otherwise taken=0,
//     next=pc+4. Adds modulo 2^32.
//   - Delivery: combinational. FETCH with mem_ready and no discard -> outputs = {pc, mem_rdata,
//     taken}. HOLD -> outputs = buffer. All other cycles -> if_pc=pc, if_instruction=0,
//     if_prediction=0 (bubble).
//   - FETCH+ready, stall_state[2]=0: pc<=req_addr<=next; stays FETCH (1 instr/cycle at 0-wait).
//   - FETCH+ready, stall_state[2]=1: buffer <= delivered values; state<=HOLD; mem_req drops.
//   - HOLD, stall_state[2]=0: IF/ID consumes at this edge; pc<=req_addr<=next(buf); ->FETCH.
//   - discard has priority over everything: pc<=req_addr<=target.
//     FETCH without ready -> DROP (req_addr keeps old address until ready, then takes target);
//     FETCH with ready -> data dropped, stay FETCH; HOLD -> buffer dropped, ->FETCH;
//     DROP -> target updated, stay DROP.
//   - DROP+ready: data discarded; req_addr<=pc; ->FETCH. Outputs are bubbles throughout.
//   - pred_index = req_addr.
//   - Reset mid-request: async clear; the memory model must tolerate an abandoned request.
// CONFIGURATION
//   ICACHE_EN defined: direct-mapped cache indexed by req_addr[2+:log2(ICACHE_LINES)],
//     with tag+valid. In FETCH a hit delivers same-cycle as if mem_ready=1 with mem_req=0;
//     a miss issues mem_req and fills the line on mem_ready, including during DROP.
//     Valid bits clear only on reset.
//   ICACHE_EN undefined: no cache storage; every fetch goes to memory.
// TESTING
//   1 Reset, 0-wait memory of NOPs (32'h00000013) -> if_pc 0,4,8,... one per cycle; prediction 0.
//   2 Word@0x10 = JAL +0x20 (32'h0200006F) -> next fetch address 0x30, if_prediction=1.
//   3 BRANCH @0x40, imm=-8, pred_taken=1 -> next addr 0x38; pred_taken=0 -> next addr 0x44.
//   4 stall_state[2]=1 for 3 cycles at delivery -> outputs stable, mem_req=0;
//     release -> IF/ID loads once; no duplicate or skipped PC.
//   5 discard target 0x100 while 3-cycle fetch of 0x08 is pending -> mem_addr held at 0x08
//     until ready, its data never delivered; next request 0x100, first real output pc=0x100.
//   6 ICACHE_EN: loop 0x0..0xC twice -> second pass has no mem_req and is 1 instr/cycle;
//     rst low mid-loop -> pc=RESET_PC and all lines miss.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory fetch port: request/address out, ready/data back.
interface if_stage_if;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches words, predecodes JAL/BRANCH for
// next-PC selection and presents pc/instruction/prediction to IF/ID.
// Optional feature macro: ICACHE_EN adds a direct-mapped one-word-per-line I-cache.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_state,
    input  logic        discard,
    input  logic [31:0] discard_target,
    input  logic        pred_taken,
    output logic [31:0] pred_index,
    if_stage_if.master  mem,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_prediction
);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {FETCH, DROP, HOLD} state_t;

    // A cache line count that is not a power of 2 cannot be indexed by address bits.
    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("if_stage: ICACHE_LINES must be a power of 2 and at least 2");
    end

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx, req_addr, req_addr_nx;
    logic [31:0] buf_pc, buf_instr;
    logic        buf_pred, buf_load;
    logic        fetch_ready, fetch_taken, stall_hold;
    logic [31:0] fetch_data, fetch_next, buf_next, target;
    logic        unused_bits;

    // Next PC for a word at p: taken JAL/BRANCH add their immediate, else fall through.
    function automatic logic [31:0] next_pc_f(input logic [31:0] p, input logic [31:0] i,
                                              input logic taken);
        logic [31:0] j_imm, b_imm;
        j_imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        b_imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
        if (taken && i[6:0] == OP_JAL)    return p + j_imm;
        if (taken && i[6:0] == OP_BRANCH) return p + b_imm;
        return p + 32'd4;
    endfunction

    assign stall_hold  = stall_state[2];
    assign target      = {discard_target[31:2], 2'b00};
    assign pred_index  = req_addr;
    assign mem.addr    = req_addr;
    assign unused_bits = ^{stall_state[5:3], stall_state[1:0], discard_target[1:0]};

`ifdef ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [31:0]       c_data [ICACHE_LINES];
    logic [TAG_W-1:0]  c_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] c_valid;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              hit, fill;

    assign idx  = req_addr[2 +: IDX_W];
    assign tag  = req_addr[31 -: TAG_W];
    assign hit  = (state == FETCH) && c_valid[idx] && (c_tag[idx] == tag);
    assign fill = mem.req && mem.ready;

    assign mem.req     = (state == DROP) || ((state == FETCH) && !hit);
    assign fetch_ready = (state == FETCH) && (hit || mem.ready);
    assign fetch_data  = hit ? c_data[idx] : mem.rdata;

    // Valid bits only clear on reset; every completed memory read fills its line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_valid <= '0;
        end else if (fill) begin
            c_valid[idx] <= 1'b1;
        end
    end

    // Line storage needs no reset: valid gates every use.
    always_ff @(posedge clk) begin
        if (fill) begin
            c_data[idx] <= mem.rdata;
            c_tag[idx]  <= tag;
        end
    end
`else
    assign mem.req     = (state != HOLD);
    assign fetch_ready = (state == FETCH) && mem.ready;
    assign fetch_data  = mem.rdata;
`endif

    assign fetch_taken = (fetch_data[6:0] == OP_JAL) ||
                         ((fetch_data[6:0] == OP_BRANCH) && pred_taken);
    assign fetch_next  = next_pc_f(pc, fetch_data, fetch_taken);
    assign buf_next    = next_pc_f(buf_pc, buf_instr, buf_pred);

    // State, PC and IF/ID holding buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            req_addr  <= RESET_PC;
            buf_pc    <= '0;
            buf_instr <= '0;
            buf_pred  <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
            if (buf_load) begin
                buf_pc    <= pc;
                buf_instr <= fetch_data;
                buf_pred  <= fetch_taken;
            end
        end
    end

    // Next-state, PC update and combinational delivery to IF/ID.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        req_addr_nx    = req_addr;
        buf_load       = 1'b0;
        if_pc          = pc;
        if_instruction = '0;
        if_prediction  = 1'b0;
        case (state)
            FETCH: begin
                if (fetch_ready && !discard) begin
                    if_instruction = fetch_data;
                    if_prediction  = fetch_taken;
                end
                if (discard) begin
                    pc_nx = target;
                    if (fetch_ready) begin
                        req_addr_nx = target;
                    end else begin
                        state_nx = DROP;
                    end
                end else if (fetch_ready) begin
                    if (stall_hold) begin
                        buf_load = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        pc_nx       = fetch_next;
                        req_addr_nx = fetch_next;
                    end
                end
            end
            DROP: begin
                if (discard) begin
                    pc_nx = target;
                end
                if (mem.ready) begin
                    req_addr_nx = discard ? target : pc;
                    state_nx    = FETCH;
                end
            end
            HOLD: begin
                if_pc          = buf_pc;
                if_instruction = buf_instr;
                if_prediction  = buf_pred;
                if (discard) begin
                    pc_nx       = target;
                    req_addr_nx = target;
                    state_nx    = FETCH;
                end else if (!stall_hold) begin
                    pc_nx       = buf_next;
                    req_addr_nx = buf_next;
                    state_nx    = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized stall/discard/
// latency traffic, checked against a program-level model of the instruction stream.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int unsigned K_OTHER  = 0;
    localparam int unsigned K_JAL    = 1;
    localparam int unsigned K_BR     = 2;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_state;
    logic        discard;
    logic [31:0] discard_target;
    logic        pred_taken;
    logic [31:0] pred_index;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_prediction;

    if_stage_if mem_bus ();

    if_stage #(.RESET_PC(RESET_PC), .ICACHE_LINES(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_state    (stall_state),
        .discard        (discard),
        .discard_target (discard_target),
        .pred_taken     (pred_taken),
        .pred_index     (pred_index),
        .mem            (mem_bus),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_prediction  (if_prediction)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prog [256];
    int unsigned kind [256];
    int          off  [256];
    logic [31:0] exp_pc;
    int          n_consumed = 0;
    logic        pend;
    logic [31:0] pend_addr;
    int unsigned lat_min, lat_max, cnt, cur_lat;
    logic [31:0] pred_mask;
    logic        pred_inv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predictor stand-in: a fixed hash of the looked-up PC.
    assign pred_taken = (^(pred_index & pred_mask)) ^ pred_inv;

    // Memory: each request completes after cur_lat extra cycles; abandoned requests are dropped.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 0;
            cur_lat <= lat_min;
        end else if (mem_bus.req && !mem_bus.ready) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
            if (mem_bus.ready) cur_lat <= $urandom_range(lat_max, lat_min);
        end
    end

    always_comb begin
        mem_bus.ready = mem_bus.req && (cnt >= cur_lat);
        mem_bus.rdata = mem_bus.ready ? prog[mem_bus.addr[9:2]] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_jal(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_br(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Expected prediction for the word at p: JAL always, BRANCH per predictor.
    function automatic logic exp_pred(input logic [31:0] p);
        case (kind[p[9:2]])
            K_JAL:   return 1'b1;
            K_BR:    return (^(p & pred_mask)) ^ pred_inv;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] p);
        if (exp_pred(p)) return p + 32'(off[p[9:2]]);
        return p + 32'd4;
    endfunction

    task automatic fill_nops();
        for (int i = 0; i < 256; i++) begin
            prog[i] = NOP;
            kind[i] = K_OTHER;
            off[i]  = 0;
        end
    endtask

    task automatic randomize_prog();
        for (int i = 0; i < 256; i++) begin
            int unsigned r;
            int o;
            r = $urandom_range(9, 0);
            o = (int'($urandom_range(32, 0)) - 16) * 4;
            if (r == 0) begin
                prog[i] = enc_jal(21'(o)); kind[i] = K_JAL; off[i] = o;
            end else if (r <= 2) begin
                prog[i] = enc_br(13'(o)); kind[i] = K_BR; off[i] = o;
            end else begin
                prog[i] = {25'($urandom), 7'b0010011}; kind[i] = K_OTHER; off[i] = 0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        discard = 1'b0;
        stall_state = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        exp_pc = RESET_PC;
        pend = 1'b0;
    endtask

    // One clock: protocol checks, scoreboard update on each IF/ID load, then advance.
    task automatic step();
        #1;
        if (rst) begin
            if (mem_bus.req) check("addr_align", 32'(mem_bus.addr[1:0]), 32'd0);
            if (pend) check("addr_stable", mem_bus.addr, pend_addr);
            if (!discard && !stall_state[2] && if_instruction !== 32'h0) begin
                check("deliv_pc", if_pc, exp_pc);
                check("deliv_instr", if_instruction, prog[exp_pc[9:2]]);
                check("deliv_pred", 32'(if_prediction), 32'(exp_pred(exp_pc)));
                exp_pc = model_next(exp_pc);
                n_consumed++;
            end
            if (discard) exp_pc = {discard_target[31:2], 2'b00};
            pend = mem_bus.req && !mem_bus.ready;
            pend_addr = mem_bus.addr;
        end else begin
            pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        bit found;
        rst = 1'b0;
        stall_state = '0;
        discard = 1'b0;
        discard_target = '0;
        pred_mask = '0;
        pred_inv = 1'b0;
        lat_min = 0;
        lat_max = 0;
        pend = 1'b0;
        exp_pc = RESET_PC;

        // Sequential NOPs at zero wait: one instruction per cycle.
        fill_nops();
        do_reset();
        #1;
        check("t1_rst_pc", if_pc, RESET_PC);
        check("t1_rst_req", 32'(mem_bus.req), 32'd1);
        check("t1_rst_pidx", pred_index, RESET_PC);
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t1_pc", if_pc, 32'(4 * i));
            check("t1_pred", 32'(if_prediction), 32'd0);
            step();
        end

        // JAL +0x20 at 0x10 redirects the next fetch to 0x30.
        fill_nops();
        prog[4] = 32'h0200_006F; kind[4] = K_JAL; off[4] = 32'h20;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        #1;
        check("t2_pc", if_pc, 32'h10);
        check("t2_instr", if_instruction, 32'h0200_006F);
        check("t2_pred", 32'(if_prediction), 32'd1);
        step();
        #1;
        check("t2_next", mem_bus.addr, 32'h30);
        step();

        // BRANCH -8 at 0x40, predicted taken then not taken.
        fill_nops();
        prog[16] = enc_br(13'(-8)); kind[16] = K_BR; off[16] = -8;
        pred_mask = '0;
        pred_inv = 1'b1;
        do_reset();
        discard = 1'b1; discard_target = 32'h40;
        step();
        discard = 1'b0;
        #1;
        check("t3_pc", if_pc, 32'h40);
        check("t3_pred_t", 32'(if_prediction), 32'd1);
        step();
        #1;
        check("t3_next_t", mem_bus.addr, 32'h38);
        step();
        pred_inv = 1'b0;
        discard = 1'b1; discard_target = 32'h40;
        step();
        discard = 1'b0;
        #1;
        check("t3_pred_nt", 32'(if_prediction), 32'd0);
        step();
        #1;
        check("t3_next_nt", mem_bus.addr, 32'h44);
        step();

        // Stall at delivery for 3 cycles: held outputs, no request, single load on release.
        fill_nops();
        do_reset();
        for (int i = 0; i < 3; i++) step();
        c0 = n_consumed;
        stall_state = 6'b000100;
        #1;
        check("t4_first", if_pc, 32'hC);
        step();
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_hold_pc", if_pc, 32'hC);
            check("t4_hold_instr", if_instruction, NOP);
            check("t4_hold_req", 32'(mem_bus.req), 32'd0);
            step();
        end
        stall_state = '0;
        step();
        #1;
        check("t4_once", 32'(n_consumed - c0), 32'd1);
        check("t4_after", if_pc, 32'h10);
        step();

        // Discard during a 3-cycle fetch of 0x08: old address held, data dropped.
        fill_nops();
        lat_min = 2; lat_max = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (mem_bus.addr == 32'h8) found = 1'b1;
            else step();
        end
        check("t5_reach", 32'(found), 32'd1);
        discard = 1'b1; discard_target = 32'h103;
        step();
        discard = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            check("t5_held", mem_bus.addr, 32'h8);
            check("t5_bubble", if_instruction, 32'h0);
            found = mem_bus.ready;
            step();
        end
        check("t5_done", 32'(found), 32'd1);
        #1;
        check("t5_newreq", mem_bus.addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            #1;
            if (if_instruction !== 32'h0) begin
                found = 1'b1;
                check("t5_first_pc", if_pc, 32'h100);
            end
            step();
        end
        check("t5_delivered", 32'(found), 32'd1);

`ifdef ICACHE_EN
        // Loop 0x0..0xC: second pass served from the cache; reset invalidates.
        fill_nops();
        prog[3] = enc_jal(21'(-12)); kind[3] = K_JAL; off[3] = -12;
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 40 && n_consumed - c0 < 0; i++) step();
        c0 = n_consumed;
        for (int i = 0; i < 40 && n_consumed - c0 < 4; i++) step();
        check("t6_pass1", 32'(n_consumed - c0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t6_noreq", 32'(mem_bus.req), 32'd0);
            check("t6_pc", if_pc, 32'(4 * i));
            check("t6_hit", 32'(if_instruction != 32'h0), 32'd1);
            step();
        end
        step();
        do_reset();
        #1;
        check("t6_rst_pc", if_pc, RESET_PC);
        check("t6_rst_miss", 32'(mem_bus.req), 32'd1);
        check("t6_rst_bubble", if_instruction, 32'h0);
        step();
`endif

        // Random programs, latencies, stalls, discards and occasional resets.
        for (int r = 0; r < 4; r++) begin
            randomize_prog();
            lat_min = 0; lat_max = 3;
            pred_mask = $urandom;
            pred_inv = 1'($urandom);
            do_reset();
            c0 = n_consumed;
            for (int c = 0; c < 300; c++) begin
                stall_state = 6'($urandom);
                stall_state[2] = ($urandom_range(3, 0) == 0);
                discard = ($urandom_range(24, 0) == 0);
                discard_target = {22'h0, 10'($urandom)};
                if ($urandom_range(199, 0) == 0) do_reset();
                else step();
            end
            discard = 1'b0;
            stall_state = '0;
            check("rand_progress", 32'(n_consumed - c0 > 20), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
